// File: rtl/core_ctrl_pkg.sv
// Shared types and default sizing for the run controller.
package core_ctrl_pkg;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_MAX_OUT = 4;
    localparam int DEF_OUT_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } run_state_e;

endpackage

// File: rtl/run_outstanding_cnt.sv
// In-flight operation counter: +1 per accepted op, -1 per completion,
// with a cap flag and a sticky underflow error.
module run_outstanding_cnt
    import core_ctrl_pkg::*;
#(
    parameter int OUT_W   = DEF_OUT_W,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clr_err,
    output logic [OUT_W-1:0] o_cnt,
    output logic             o_cap,
    output logic             o_dec_ok,
    output logic             o_err
);

    logic [OUT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_dec_ok;

    // A completion in the same cycle as its own accept (zero-latency
    // datapath) is legal; only a completion with nothing in flight is stray.
    assign w_dec_ok = i_dec && ((r_cnt != '0) || i_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            case ({i_inc, w_dec_ok})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (i_dec && !w_dec_ok)
                r_err <= 1'b1;
            else if (i_clr_err)
                r_err <= 1'b0;
        end
    end

    assign o_cnt    = r_cnt;
    assign o_cap    = (r_cnt >= OUT_W'(MAX_OUT));
    assign o_dec_ok = w_dec_ok;
    assign o_err    = r_err;

endmodule

// File: rtl/core_run_ctrl.sv
// Run sequencer: issues N ops over valid/ready with an in-flight cap,
// counts completions and pulses done when the last one returns.
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MAX_OUT = DEF_MAX_OUT,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_ops_i,
    output logic             op_valid_o,
    input  logic             op_ready_i,
    output logic [CNT_W-1:0] op_idx_o,
    input  logic             resp_valid_i,
    output logic             idle_o,
    output logic             done_o,
    output logic             err_o,
    output logic [OUT_W-1:0] outstanding_o
);

    run_state_e       r_state;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_issue_cnt;
    logic [CNT_W-1:0] r_cmp_cnt;

    logic w_cap, w_xfer, w_cmp, w_start_ok;
    logic w_last_issue, w_last_cmp;

    assign w_start_ok   = (r_state == ST_IDLE) && start_i;
    // Cap comes from the registered count, so valid cannot drop mid-handshake.
    assign op_valid_o   = (r_state == ST_ISSUE) && !w_cap;
    assign w_xfer       = op_valid_o && op_ready_i;
    assign w_last_issue = w_xfer && (r_issue_cnt == r_num - 1'b1);
    assign w_last_cmp   = w_cmp && (r_cmp_cnt == r_num - 1'b1);

    run_outstanding_cnt #(
        .OUT_W   (OUT_W),
        .MAX_OUT (MAX_OUT)
    ) u_out_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (w_xfer),
        .i_dec     (resp_valid_i),
        .i_clr_err (w_start_ok),
        .o_cnt     (outstanding_o),
        .o_cap     (w_cap),
        .o_dec_ok  (w_cmp),
        .o_err     (err_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_num       <= '0;
            r_issue_cnt <= '0;
            r_cmp_cnt   <= '0;
        end else begin
            if (w_xfer) r_issue_cnt <= r_issue_cnt + 1'b1;
            if (w_cmp)  r_cmp_cnt   <= r_cmp_cnt + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (num_ops_i != '0) begin
                            r_num       <= num_ops_i;
                            r_issue_cnt <= '0;
                            r_cmp_cnt   <= '0;
                            r_state     <= ST_ISSUE;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_last_issue)
                        r_state <= w_last_cmp ? ST_DONE : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_last_cmp) r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign idle_o   = (r_state == ST_IDLE);
    assign done_o   = (r_state == ST_DONE);
    assign op_idx_o = r_issue_cnt;

endmodule
